rv32i_imem_loader: RTL and testbench

//   Writer side of the instruction memory: receives a program as a byte stream
//   (e.g. from a UART RX) and writes it into instruction memory as little-endian
//   32-bit words at byte addresses 0,4,8,...

---
 rtl/rv32i_imem_loader.sv | 141 ++++++++++++++
 tb/tb_rv32i_imem_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_imem_loader.sv
// Boot loader for the instruction memory. It turns a little-endian byte stream
// (a word count, then the words) into 32-bit memory writes and holds the core in reset until the image is complete.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset; stream not accepted, waiting for start
// S_LEN   | receiving the 4-byte word count N
// S_DATA  | receiving words and writing each complete word to memory
// S_DONE  | image complete; core released
// S_ERROR | header asked for more words than the memory holds
module rv32i_imem_loader #(
  parameter int INSTR_MEM_DEPTH = 1024,
  parameter int CNT_W           = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [23:0]       byte_sr;
  logic [CNT_W-1:0]  word_idx;
  logic [CNT_W-1:0]  n_words;
  logic              accept;
  logic              last_byte;
  logic              last_word;
  logic              start_load;
  logic [31:0]       full_word;

  assign accept     = rx_valid && rx_ready;
  assign last_byte  = accept && (byte_cnt == 2'd3);
  // The three earlier bytes already sit in byte_sr, lowest byte at bit 0.
  assign full_word  = {rx_data, byte_sr};
  assign last_word  = (word_idx == (n_words - CNT_W'(1)));
  assign start_load = start && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (last_byte) begin
          if (full_word == 32'd0)                         state_nxt = S_DONE;
          else if (full_word > 32'(INSTR_MEM_DEPTH))      state_nxt = S_ERROR;
          else                                            state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte && last_word) state_nxt = S_DONE;
      end
      S_DONE, S_ERROR: begin
        if (start) state_nxt = S_LEN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    core_hold = 1'b1;
    case (state)
      S_LEN, S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      byte_sr  <= '0;
      word_idx <= '0;
      n_words  <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      we <= 1'b0;
      if (start_load) begin
        byte_cnt <= '0;
        byte_sr  <= '0;
        word_idx <= '0;
        n_words  <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        byte_sr  <= {rx_data, byte_sr[23:8]};
        if (last_byte && (state == S_LEN)) begin
          n_words <= full_word[CNT_W-1:0];
        end
        if (last_byte && (state == S_DATA)) begin
          we       <= 1'b1;
          waddr    <= {{(30-CNT_W){1'b0}}, word_idx, 2'b00};
          wdata    <= full_word;
          word_idx <= word_idx + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Bench for rv32i_imem_loader: directed images; expected writes are queued by the
// stimulus and checked by an independent write monitor.
module tb_rv32i_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        core_hold;

  rv32i_imem_loader #(.INSTR_MEM_DEPTH(1024), .CNT_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .core_hold (core_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_writes = 0;
  bit   rand_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every we pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && we !== 1'b0) begin
      n_writes++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got write at %h data %h, expected no write", waddr, wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("waddr", waddr, e.addr);
        check("wdata", wdata, e.data);
        check("we_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle count seen just before the edge that transfers the byte.
  task automatic send_byte(input logic [7:0] b, output int hs_cyc);
    if (rand_mode) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        tick();
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    hs_cyc   = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        hs_cyc = cyc;
        tick();
        break;
      end
      tick();
    end
    rx_valid = 1'b0;
    if (hs_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: got no rx_ready within 50 cycles, expected acceptance");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit is_write);
    int hs;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], hs);
      if (k == 3 && is_write) sb.push_back('{addr: addr, data: w, cyc: hs + 1});
    end
  endtask

  task automatic check_status(input string tag, input logic e_busy, input logic e_done,
                              input logic e_err, input logic e_hold, input logic e_rdy);
    check({tag, "_busy"}, 32'(busy), 32'(e_busy));
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_error"}, 32'(error), 32'(e_err));
    check({tag, "_core_hold"}, 32'(core_hold), 32'(e_hold));
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'(e_rdy));
  endtask

  initial begin
    int w0;
    logic [31:0] img2 [2];
    img2[0] = 32'h0000_0013;
    img2[1] = 32'h0010_0093;

    // 1: reset values, stream ignored without start
    #12;
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_we", 32'(we), 32'd0);
    check("reset_waddr", waddr, 32'd0);
    check("reset_wdata", wdata, 32'd0);
    rst_n = 1'b1;
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_rx_ready", 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    check("idle_no_writes", n_writes, 0);

    // 2: two-word image, back-to-back bytes
    pulse_start();
    check_status("len", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    w0 = n_writes;
    send_word(32'd2, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) send_word(img2[i], 32'(i * 4), 1'b1);
    tick();
    check_status("img2_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("img2_writes", n_writes - w0, 2);
    check("img2_wdata_hold", wdata, 32'h0010_0093);
    check("img2_waddr_hold", waddr, 32'd4);

    // 3: same image with random rx_valid gaps
    rand_mode = 1'b1;
    pulse_start();
    w0 = n_writes;
    send_word(32'd2, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) send_word(img2[i], 32'(i * 4), 1'b1);
    tick();
    check_status("rand_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rand_writes", n_writes - w0, 2);
    rand_mode = 1'b0;

    // 4: empty image
    pulse_start();
    w0 = n_writes;
    send_word(32'd0, 32'd0, 1'b0);
    check_status("n0_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("n0_writes", n_writes - w0, 0);

    // 5: oversize header, then clean reload
    pulse_start();
    w0 = n_writes;
    send_word(32'd1025, 32'd0, 1'b0);
    check_status("n1025_error", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    check("n1025_writes", n_writes - w0, 0);
    pulse_start();
    check_status("reload_len", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word(32'd1, 32'd0, 1'b0);
    send_word(32'hDEAD_BEEF, 32'd0, 1'b1);
    tick();
    check_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-load, then full load
    pulse_start();
    w0 = n_writes;
    send_word(32'd3, 32'd0, 1'b0);
    begin
      int hs;
      send_byte(8'h11, hs);
      send_byte(8'h22, hs);
    end
    #2 rst_n = 1'b0;
    #1;
    check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("midrst_waddr", waddr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_writes", n_writes - w0, 0);
    pulse_start();
    send_word(32'd3, 32'd0, 1'b0);
    send_word(32'h0000_0001, 32'd0, 1'b1);
    send_word(32'h8000_0002, 32'd4, 1'b1);
    send_word(32'h1234_5678, 32'd8, 1'b1);
    tick();
    check_status("n3_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("n3_writes", n_writes - w0, 3);

    // Boundary: full-depth image, last write at 0xFFC
    pulse_start();
    w0 = n_writes;
    send_word(32'd1024, 32'd0, 1'b0);
    for (int i = 0; i < 1024; i++) send_word(32'hC000_0000 ^ 32'(i * 32'h0001_0003), 32'(i * 4), 1'b1);
    tick();
    check_status("full_done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_writes", n_writes - w0, 1024);
    check("full_last_waddr", waddr, 32'h0000_0FFC);

    repeat (2) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
